// File: rtl/icache_responder_pkg.sv
// Shared definitions for the instruction-cache responder: response bus layout
// and FSM state encoding, used by the cache and by the fetch stage.
package icache_responder_pkg;

   // Bit positions of the response fields on the fetch bus
   localparam int ICBUS_HIT     = 32;
   localparam int ICBUS_INSTR_H = 31;
   localparam int ICBUS_INSTR_L = 0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REFILL    = 2'd1,
      ST_FILL_DONE = 2'd2
   } ic_state_t;

   // Packed so that hit lands on bit 32 and the instruction on bits 31:0
   typedef struct packed {
      logic        hit;
      logic [31:0] instr;
   } ic_resp_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache; master is the fetch stage plus memory.
interface icache_responder_if
   import icache_responder_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] addr;
   ic_resp_t          resp;
   logic              inval;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic [31:0]       mem_data;

   modport slave  (input addr, inval, mem_valid, mem_data,
                   output resp, mem_req, mem_addr);
   modport master (output addr, inval, mem_valid, mem_data,
                   input resp, mem_req, mem_addr);
endinterface

// File: rtl/icache_responder_data_array.sv
// Instruction data storage: NUM_LINES x LINE_WORDS words, one synchronous
// write port for refill beats, one asynchronous read port for lookups.
module icache_data_array #(
   parameter int NUM_LINES  = 64,
   parameter int LINE_WORDS = 4,
   localparam int IDX_W     = $clog2(NUM_LINES),
   localparam int WSEL_W    = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [WSEL_W-1:0] wword,
   input  logic [31:0]       wdata,
   input  logic [IDX_W-1:0]  ridx,
   input  logic [WSEL_W-1:0] rword,
   output logic [31:0]       rdata
);
   logic [31:0] mem [NUM_LINES][LINE_WORDS];

   // Refill write; contents are never reset, the valid bits guard them
   always_ff @(posedge clk) begin
      if (we) mem[widx][wword] <= wdata;
   end

   assign rdata = mem[ridx][rword];
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped, read-only, blocking instruction cache responder.
// Zero-latency combinational hit path; misses refill one line word-serially.
module icache_responder
   import icache_responder_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 64,
   parameter int ADDR_W     = 32
) (
   input logic               clk,
   input logic               rst,
   icache_responder_if.slave bus
);
   localparam int WSEL_W = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int OFF    = WSEL_W + 2;
   localparam int TAG_W  = ADDR_W - OFF - IDX_W;
   localparam logic [WSEL_W-1:0] LAST = WSEL_W'(LINE_WORDS - 1);

   logic [WSEL_W-1:0] word;
   logic [IDX_W-1:0]  index;
   logic [TAG_W-1:0]  tag;

   ic_state_t         state;
   logic [WSEL_W-1:0] cnt;
   logic [IDX_W-1:0]  idx_q;
   logic [TAG_W-1:0]  tag_q;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]  tag_arr [NUM_LINES];
   logic              discard;
   logic [31:0]       rdata;
   logic              hit;
   logic              beat;
   logic              last_beat;

   assign word  = bus.addr[OFF-1:2];
   assign index = bus.addr[OFF+IDX_W-1:OFF];
   assign tag   = bus.addr[ADDR_W-1:OFF+IDX_W];

   // Lookup only in IDLE: the cache blocks completely while a line is in flight
   assign hit       = !rst && (state == ST_IDLE) && valid[index] && (tag_arr[index] == tag);
   assign bus.resp  = hit ? ic_resp_t'{hit: 1'b1, instr: rdata} : '0;
   assign beat      = (state == ST_REFILL) && bus.mem_valid;
   assign last_beat = beat && (cnt == LAST);

   icache_data_array #(
      .NUM_LINES (NUM_LINES),
      .LINE_WORDS(LINE_WORDS)
   ) u_data (
      .clk  (clk),
      .we   (beat && !rst),
      .widx (idx_q),
      .wword(cnt),
      .wdata(bus.mem_data),
      .ridx (index),
      .rword(word),
      .rdata(rdata)
   );

   // Tag is committed with the final beat; tags are not reset
   always_ff @(posedge clk) begin
      if (!rst && last_beat) tag_arr[idx_q] <= tag_q;
   end

   // Refill FSM with registered memory request/address and the valid bits
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         valid        <= '0;
         discard      <= 1'b0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Invalidate beats a simultaneous miss: no refill this cycle
               if (!bus.inval && !hit) begin
                  state        <= ST_REFILL;
                  idx_q        <= index;
                  tag_q        <= tag;
                  cnt          <= '0;
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= {bus.addr[ADDR_W-1:OFF], {OFF{1'b0}}};
               end
            end
            ST_REFILL: begin
               if (bus.mem_valid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     if (!discard) valid[idx_q] <= 1'b1;
                     state       <= ST_FILL_DONE;
                     bus.mem_req <= 1'b0;
                  end else begin
                     // Stays inside the line: at most LINE_WORDS-1 steps from the base
                     bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
                  end
               end
            end
            ST_FILL_DONE: begin
               state   <= ST_IDLE;
               discard <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
         // Placed after the case so a flush on the last beat still wins
         if (bus.inval) valid <= '0;
         if (bus.inval && state == ST_REFILL) discard <= 1'b1;
      end
   end
endmodule
